dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter_if.sv | 57 +++++
 rtl/dram_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if -- bundle of all non-clock signals of the DRAM arbiter.
//   Phase strobes : cbeg, post_cbeg, pre_cend, cend (one-hot per fclk)
//   CPU port      : cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel in;
//                   cpu_next, cpu_strobe, cpu_rddata out
//   Video port    : video_req, video_addr in; video_next, video_strobe,
//                   video_rddata out
//   DRAM side     : dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel out;
//                   dram_rddata in
// Modport slave is the arbiter's view, master is the surrounding system's view.
interface dram_arbiter_if;
  logic        cbeg;
  logic        post_cbeg;
  logic        pre_cend;
  logic        cend;

  logic        cpu_req;
  logic        cpu_rnw;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        cpu_wrbsel;
  logic        cpu_next;
  logic        cpu_strobe;
  logic [15:0] cpu_rddata;

  logic        video_req;
  logic [20:0] video_addr;
  logic        video_next;
  logic        video_strobe;
  logic [15:0] video_rddata;

  logic        dram_req;
  logic        dram_rnw;
  logic [20:0] dram_addr;
  logic [15:0] dram_wrdata;
  logic [1:0]  dram_bsel;
  logic [15:0] dram_rddata;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel,
    input  video_req, video_addr,
    input  dram_rddata,
    output cbeg, post_cbeg, pre_cend, cend,
    output cpu_next, cpu_strobe, cpu_rddata,
    output video_next, video_strobe, video_rddata,
    output dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_wrbsel,
    output video_req, video_addr,
    output dram_rddata,
    input  cbeg, post_cbeg, pre_cend, cend,
    input  cpu_next, cpu_strobe, cpu_rddata,
    input  video_next, video_strobe, video_rddata,
    input  dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter -- shares one DRAM between a CPU and a video fetcher.
// Every DRAM cycle is four fclk long (cbeg, post_cbeg, pre_cend, cend). The
// owner of the next cycle is chosen during cend: video wins unless it has had
// three consecutive grants while the CPU was waiting, in which case the CPU
// gets the cycle. Read data is captured at the end of pre_cend and announced
// with a one-fclk strobe during cend.
// Ports:
//   fclk  : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dram_arbiter_if.slave (phase strobes, CPU, video and DRAM signals)
module dram_arbiter (
  input  logic               fclk,
  input  logic               rst_n,
  dram_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    PH_CBEG = 2'd0,
    PH_POST = 2'd1,
    PH_PRE  = 2'd2,
    PH_CEND = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_VIDEO = 2'd2
  } owner_t;

  phase_t      phase;
  phase_t      phase_nxt;

  owner_t      owner;
  logic [1:0]  vcnt;

  logic        req_q;
  logic        rnw_q;
  logic [20:0] addr_q;
  logic [15:0] wrdata_q;
  logic [1:0]  bsel_q;

  logic        cpu_stb_q;
  logic        video_stb_q;
  logic [15:0] cpu_buf;
  logic [15:0] video_buf;

  logic        at_cend;
  logic        forced_cpu;
  logic        video_win;
  logic        cpu_win;
  logic        read_owned;

  // ---------------------------------------------------------------------
  // Phase sequencer: state register
  // Reset parks the sequencer in cend so the first rising edge after
  // release enters cbeg.
  // ---------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_CEND;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Phase sequencer: next state
  always_comb begin
    phase_nxt = PH_CBEG;
    case (phase)
      PH_CBEG: phase_nxt = PH_POST;
      PH_POST: phase_nxt = PH_PRE;
      PH_PRE:  phase_nxt = PH_CEND;
      PH_CEND: phase_nxt = PH_CBEG;
      default: phase_nxt = PH_CBEG;
    endcase
  end

  // Phase sequencer: one-hot phase strobes
  always_comb begin
    bus.cbeg      = 1'b0;
    bus.post_cbeg = 1'b0;
    bus.pre_cend  = 1'b0;
    bus.cend      = 1'b0;
    case (phase)
      PH_CBEG: bus.cbeg      = 1'b1;
      PH_POST: bus.post_cbeg = 1'b1;
      PH_PRE:  bus.pre_cend  = 1'b1;
      PH_CEND: bus.cend      = 1'b1;
      default: bus.cend      = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Arbitration decision (evaluated every fclk, acted upon only in cend)
  // ---------------------------------------------------------------------
  always_comb begin
    at_cend    = (phase == PH_CEND);
    forced_cpu = bus.cpu_req && (vcnt == 2'd3);
    video_win  = bus.video_req && !forced_cpu;
    cpu_win    = !video_win && bus.cpu_req;
    read_owned = req_q && rnw_q;
  end

  // The CPU may use the next cycle whenever video cannot claim it,
  // regardless of whether the CPU is currently asking.
  assign bus.cpu_next   = !bus.video_req || (vcnt == 2'd3);
  // Grant is combinational in cend; gated so it stays low while in reset.
  assign bus.video_next = rst_n && at_cend && video_win;

  // ---------------------------------------------------------------------
  // Cycle ownership and DRAM command registers, loaded at the end of cend
  // and held for the whole owned cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= OWN_IDLE;
      vcnt     <= 2'd0;
      req_q    <= 1'b0;
      rnw_q    <= 1'b1;
      addr_q   <= 21'd0;
      wrdata_q <= 16'd0;
      bsel_q   <= 2'b11;
    end else if (at_cend) begin
      if (video_win) begin
        owner  <= OWN_VIDEO;
        req_q  <= 1'b1;
        rnw_q  <= 1'b1;
        addr_q <= bus.video_addr;
        bsel_q <= 2'b11;
        // Only grants made while the CPU waits count toward the fairness
        // limit; the counter saturates at 3 instead of wrapping.
        if (!bus.cpu_req) begin
          vcnt <= 2'd0;
        end else if (vcnt != 2'd3) begin
          vcnt <= vcnt + 2'd1;
        end
      end else if (cpu_win) begin
        owner  <= OWN_CPU;
        req_q  <= 1'b1;
        rnw_q  <= bus.cpu_rnw;
        addr_q <= bus.cpu_addr;
        vcnt   <= 2'd0;
        if (bus.cpu_rnw) begin
          bsel_q <= 2'b11;
        end else begin
          wrdata_q <= {bus.cpu_wrdata, bus.cpu_wrdata};
          bsel_q   <= bus.cpu_wrbsel ? 2'b01 : 2'b10;
        end
      end else begin
        // Idle cycle: address/data/byte-select keep their previous values.
        owner <= OWN_IDLE;
        req_q <= 1'b0;
        vcnt  <= 2'd0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read-data capture at the end of pre_cend; the strobe register is
  // therefore high exactly during the following cend.
  // ---------------------------------------------------------------------
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_stb_q   <= 1'b0;
      video_stb_q <= 1'b0;
      cpu_buf     <= 16'd0;
      video_buf   <= 16'd0;
    end else begin
      cpu_stb_q   <= 1'b0;
      video_stb_q <= 1'b0;
      if ((phase == PH_PRE) && read_owned) begin
        if (owner == OWN_CPU) begin
          cpu_buf   <= bus.dram_rddata;
          cpu_stb_q <= 1'b1;
        end else if (owner == OWN_VIDEO) begin
          video_buf   <= bus.dram_rddata;
          video_stb_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dram_req     = req_q;
  assign bus.dram_rnw     = rnw_q;
  assign bus.dram_addr    = addr_q;
  assign bus.dram_wrdata  = wrdata_q;
  assign bus.dram_bsel    = bsel_q;
  assign bus.cpu_strobe   = cpu_stb_q;
  assign bus.cpu_rddata   = cpu_buf;
  assign bus.video_strobe = video_stb_q;
  assign bus.video_rddata = video_buf;

endmodule
